ssl_xcorr: RTL and testbench

//  Parametrised next-generation sound-source-localisation correlator. Takes NCH
//  1-bit microphone streams; channel 0 is the reference. For each channel k>0 it

---
 rtl/ssl_xcorr.sv | 130 +++++++++++++
 tb/tb_ssl_xcorr.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ssl_xcorr.sv
// Windowed 1-bit cross-correlator: for each channel k>0, finds the lag by which it trails ch0.
// Uses agreement counting over WIN accepted samples, then a one-lag-per-cycle argmax scan.
module ssl_xcorr #(
   parameter int unsigned NCH  = 4,
   parameter int unsigned NLAG = 128,
   parameter int unsigned WIN  = 1024
) (
   input  logic                                  clk,
   input  logic                                  erst,
   input  logic                                  din_valid,
   output logic                                  din_ready,
   input  logic [NCH-1:0]                        din,
   output logic [(NCH-1)*$clog2(NLAG)-1:0]       dId,
   output logic [(NCH-1)*$clog2(WIN+1)-1:0]      pk,
   output logic                                  dvalid
);

   localparam int unsigned LAGW = $clog2(NLAG);
   localparam int unsigned CW   = $clog2(WIN + 1);
   localparam int unsigned NK   = NCH - 1;

   typedef enum logic [1:0] {ACC, SCAN, DONE} state_t;

   state_t              state_q;
   logic [NLAG-2:0]     hist_q;
   logic [NLAG-1:0]     ref_c;
   logic [CW-1:0]       score_q    [NK][NLAG];
   logic [CW-1:0]       cnt_q;
   logic [LAGW-1:0]     idx_q;
   logic [CW-1:0]       best_sc_q  [NK];
   logic [CW-1:0]       best_sc_d  [NK];
   logic [LAGW-1:0]     best_lag_q [NK];
   logic [LAGW-1:0]     best_lag_d [NK];
   logic [NK*LAGW-1:0]  did_q;
   logic [NK*CW-1:0]    pk_q;
   logic                dvalid_q;
   logic                ready_q;
   logic                accept_c;

   // ref_c[l] is ch0 delayed by l samples: bit 0 is the live sample, the rest is history
   assign ref_c    = {hist_q, din[0]};
   assign accept_c = (state_q == ACC) && din_valid;

   assign din_ready = ready_q;
   assign dId       = did_q;
   assign pk        = pk_q;
   assign dvalid    = dvalid_q;

   // Strict greater-than keeps the lowest lag on ties
   always_comb begin
      for (int k = 0; k < int'(NK); k++) begin
         best_sc_d[k]  = best_sc_q[k];
         best_lag_d[k] = best_lag_q[k];
         if (score_q[k][idx_q] > best_sc_q[k]) begin
            best_sc_d[k]  = score_q[k][idx_q];
            best_lag_d[k] = idx_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!erst) begin
         state_q  <= ACC;
         hist_q   <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         ready_q  <= 1'b1;
         dvalid_q <= 1'b0;
         did_q    <= '0;
         pk_q     <= '0;
         for (int k = 0; k < int'(NK); k++) begin
            best_sc_q[k]  <= '0;
            best_lag_q[k] <= '0;
            for (int l = 0; l < int'(NLAG); l++) score_q[k][l] <= '0;
         end
      end else begin
         dvalid_q <= 1'b0;
         case (state_q)
            ACC: begin
               if (accept_c) begin
                  hist_q <= ref_c[NLAG-2:0];
                  for (int k = 0; k < int'(NK); k++) begin
                     for (int l = 0; l < int'(NLAG); l++) begin
                        if (din[k+1] == ref_c[l]) score_q[k][l] <= score_q[k][l] + CW'(1);
                     end
                  end
                  if (cnt_q == CW'(WIN - 1)) begin
                     cnt_q   <= '0;
                     idx_q   <= '0;
                     ready_q <= 1'b0;
                     state_q <= SCAN;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            SCAN: begin
               for (int k = 0; k < int'(NK); k++) begin
                  best_sc_q[k]  <= best_sc_d[k];
                  best_lag_q[k] <= best_lag_d[k];
               end
               if (idx_q == LAGW'(NLAG - 1)) begin
                  // Publish on the last scan edge so results are visible during DONE
                  for (int k = 0; k < int'(NK); k++) begin
                     did_q[k*LAGW +: LAGW] <= best_lag_d[k];
                     pk_q[k*CW +: CW]      <= best_sc_d[k];
                  end
                  dvalid_q <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  idx_q <= idx_q + LAGW'(1);
               end
            end
            DONE: begin
               cnt_q   <= '0;
               idx_q   <= '0;
               ready_q <= 1'b1;
               state_q <= ACC;
               for (int k = 0; k < int'(NK); k++) begin
                  best_sc_q[k]  <= '0;
                  best_lag_q[k] <= '0;
                  for (int l = 0; l < int'(NLAG); l++) score_q[k][l] <= '0;
               end
            end
            default: state_q <= ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_ssl_xcorr.sv
// Directed bench for ssl_xcorr: delayed LFSR streams with known lags, constant input,
// sparse valid, mid-window reset, and valid held through the scan.
module tb_ssl_xcorr;

   localparam int NCH  = 4;
   localparam int NLAG = 128;
   localparam int WIN  = 1024;
   localparam int LAGW = 7;
   localparam int CW   = 11;
   localparam int NS   = 4096;

   logic                     clk;
   logic                     erst;
   logic                     din_valid;
   logic                     din_ready;
   logic [NCH-1:0]           din;
   logic [(NCH-1)*LAGW-1:0]  dId;
   logic [(NCH-1)*CW-1:0]    pk;
   logic                     dvalid;

   ssl_xcorr #(.NCH(NCH), .NLAG(NLAG), .WIN(WIN)) dut (
      .clk       (clk),
      .erst      (erst),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .din       (din),
      .dId       (dId),
      .pk        (pk),
      .dvalid    (dvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic ref_bits [NS];
   int   dly [NCH];
   int   n, period, phase, cycle;
   int   dv_count, dv_cycle, dv_n, acc_cycle, nrdy, did_bad;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Galois LFSR reference stream, or all zeros
   task automatic gen_stream(input logic [15:0] seed, input bit zero);
      logic [15:0] s;
      s = seed;
      for (int i = 0; i < NS; i++) begin
         ref_bits[i] = zero ? 1'b0 : s[0];
         s = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
      end
   endtask

   function automatic logic chan_bit(input int k, input int idx);
      return (idx >= dly[k]) ? ref_bits[idx - dly[k]] : 1'b0;
   endfunction

   // One cycle: observe outputs at negedge, then drive the next sample
   task automatic tick();
      @(negedge clk);
      cycle++;
      if (!din_ready) nrdy++;
      if (dvalid) begin
         dv_count++;
         dv_cycle = cycle;
         dv_n     = n;
      end else if (dId != '0) begin
         did_bad++;
      end
      din_valid = (phase == 0);
      phase     = (phase + 1) % period;
      for (int k = 0; k < NCH; k++) din[k] = chan_bit(k, n);
      if (din_valid && din_ready) begin
         n++;
         if (n % WIN == 0) acc_cycle = cycle;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      erst      = 1'b0;
      din_valid = 1'b0;
      din       = '0;
      @(negedge clk);
      erst    = 1'b1;
      n       = 0;
      phase   = 0;
      nrdy    = 0;
      did_bad = 0;
   endtask

   task automatic wait_dv(input string tag);
      int start;
      int i;
      start = dv_count;
      i     = 0;
      while (dv_count == start && i < 4000) begin
         tick();
         i++;
      end
      if (dv_count == start) check_eq({tag, "_timeout"}, 32'(0), 32'(1));
   endtask

   task automatic check_win(input string tag, input int e1, input int e2, input int e3, input int epk);
      int e [NCH];
      e[1] = e1; e[2] = e2; e[3] = e3;
      for (int k = 1; k < NCH; k++) begin
         check_eq($sformatf("%s_dId%0d", tag, k), 32'(dId[(k-1)*LAGW +: LAGW]), 32'(e[k]));
         check_eq($sformatf("%s_pk%0d", tag, k),  32'(pk[(k-1)*CW +: CW]),     32'(epk));
      end
   endtask

   task automatic set_dly(input int d1, input int d2, input int d3);
      dly[0] = 0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
   endtask

   initial begin
      erst = 1'b0; din_valid = 1'b0; din = '0;
      cycle = 0; dv_count = 0; dv_cycle = 0; dv_n = 0; acc_cycle = 0;
      period = 1; set_dly(0, 0, 0);
      repeat (2) @(negedge clk);
      do_reset();
      check_eq("rst_dId",    32'(dId),       32'(0));
      check_eq("rst_pk",     32'(pk),        32'(0));
      check_eq("rst_dvalid", 32'(dvalid),    32'(0));
      check_eq("rst_ready",  32'(din_ready), 32'(1));

      // Case 1/6: delays 9/6/3, valid held high through SCAN/DONE
      gen_stream(16'hACE1, 1'b0);
      set_dly(9, 6, 3); period = 1;
      do_reset();
      wait_dv("c1w1");
      check_win("c1w1", 9, 6, 3, 1024);
      check_eq("c1w1_cnt",  32'(dv_n), 32'(WIN));
      check_eq("c1w1_lat",  32'(dv_cycle - acc_cycle), 32'(NLAG + 1));
      check_eq("c1w1_nrdy", 32'(nrdy), 32'(NLAG + 1));
      nrdy = 0;
      tick();
      check_eq("c1_pulse", 32'(dvalid), 32'(0));
      wait_dv("c1w2");
      check_win("c1w2", 9, 6, 3, 1024);
      check_eq("c1w2_cnt",  32'(dv_n), 32'(2 * WIN));
      check_eq("c1w2_nrdy", 32'(nrdy), 32'(NLAG + 1));

      // Case 2: constant zero input, every lag ties
      gen_stream(16'h0001, 1'b1);
      set_dly(0, 0, 0); period = 1;
      do_reset();
      wait_dv("c2w1");
      check_win("c2w1", 0, 0, 0, 1024);

      // Case 3: lag boundaries 127 and 0
      gen_stream(16'h1D2B, 1'b0);
      set_dly(127, 0, 64); period = 1;
      do_reset();
      wait_dv("c3w1");
      check_win("c3w1", 127, 0, 64, 1024);
      wait_dv("c3w2");
      check_win("c3w2", 127, 0, 64, 1024);

      // Case 4: valid one cycle in three
      gen_stream(16'hACE1, 1'b0);
      set_dly(9, 6, 3); period = 3;
      do_reset();
      wait_dv("c4w1");
      check_win("c4w1", 9, 6, 3, 1024);
      check_eq("c4_lat",  32'(dv_cycle - acc_cycle), 32'(NLAG + 1));
      check_eq("c4_nrdy", 32'(nrdy), 32'(NLAG + 1));

      // Case 5: reset at accepted sample 500, then restart stream
      period = 1;
      do_reset();
      while (n < 500) tick();
      do_reset();
      check_eq("c5_rst_dId",   32'(dId),       32'(0));
      check_eq("c5_rst_ready", 32'(din_ready), 32'(1));
      begin
         int dv0;
         dv0 = dv_count;
         wait_dv("c5w1");
         check_eq("c5_cnt",     32'(dv_n), 32'(WIN));
         check_eq("c5_one_dv",  32'(dv_count - dv0), 32'(1));
         check_eq("c5_dId_hold", 32'(did_bad), 32'(0));
      end
      check_win("c5w1", 9, 6, 3, 1024);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
